// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions.
// Holds datapath width, FP constants and index-width helper.
package lenet_pkg;

    localparam int DATA_WIDTH = 32;

    // 4.0 in IEEE-754 single, the 2x2 average divisor
    localparam logic [31:0] FP_FOUR = 32'h4080_0000;

    // Width of an index over n items, never below one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_buffer_delay_line.sv
// Fixed-depth shift register with async reset.
// Advances every cycle so in-flight entries always drain.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock, no enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/pool_window_buffer.sv
// Line buffer feeding the 2x2 average-pooling stage.
// Forms stride-2 windows and tags each result with address and map.
module pool_window_buffer
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH            = lenet_pkg::DATA_WIDTH,
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 3,
    parameter int POOL_LATENCY          = 3,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int BUF_LEN               = IFM_SIZE + 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             data_valid,
    output logic [DATA_WIDTH-1:0]            pool_data_in_1,
    output logic [DATA_WIDTH-1:0]            pool_data_in_2,
    output logic [DATA_WIDTH-1:0]            pool_data_in_3,
    output logic [DATA_WIDTH-1:0]            pool_data_in_4,
    output logic                             pool_enable,
    output logic                             pool_out_valid,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] pool_out_addr,
    output logic [idx_w(IFM_DEPTH)-1:0]      pool_out_map,
    output logic                             frame_done
);

    // Counter width also holds 2*IFM_SIZE_NEXT for the window bound
    localparam int CNT_W  = idx_w(IFM_SIZE + 1);
    localparam int MAP_W  = idx_w(IFM_DEPTH);
    localparam int ADDR_W = ADDRESS_SIZE_NEXT_IFM;
    localparam int META_W = MAP_W + ADDR_W;

    localparam logic [CNT_W-1:0]  POS_LAST  = CNT_W'(IFM_SIZE - 1);
    localparam logic [CNT_W-1:0]  WIN_LIM   = CNT_W'(2 * IFM_SIZE_NEXT);
    localparam logic [MAP_W-1:0]  MAP_LAST  = MAP_W'(IFM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);

    logic [DATA_WIDTH-1:0] pix_buf [BUF_LEN];
    logic [CNT_W-1:0]      col;
    logic [CNT_W-1:0]      row;
    logic [MAP_W-1:0]      map;
    logic                  win;
    logic [ADDR_W-1:0]     addr_c;
    logic [META_W-1:0]     meta_q;
    logic [META_W-1:0]     meta_out;

    // Pixel shift register, moves only on accepted pixels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_LEN; i++) pix_buf[i] <= '0;
        end else if (data_valid) begin
            pix_buf[0] <= data_in;
            for (int i = 1; i < BUF_LEN; i++) pix_buf[i] <= pix_buf[i-1];
        end
    end

    assign pool_data_in_4 = pix_buf[0];
    assign pool_data_in_3 = pix_buf[1];
    assign pool_data_in_2 = pix_buf[IFM_SIZE];
    assign pool_data_in_1 = pix_buf[IFM_SIZE+1];

    // Raster position of the pixel about to be accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            map <= '0;
        end else if (data_valid) begin
            if (col == POS_LAST) begin
                col <= '0;
                if (row == POS_LAST) begin
                    row <= '0;
                    map <= (map == MAP_LAST) ? '0 : map + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Odd row/col closes a window; trailing odd-size edge is excluded
    assign win = col[0] && row[0] && (col < WIN_LIM) && (row < WIN_LIM);

    assign addr_c = ADDR_W'((int'(row) >> 1) * IFM_SIZE_NEXT + (int'(col) >> 1));

    // One-cycle window pulse plus the result tag captured with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pool_enable <= 1'b0;
            meta_q      <= '0;
        end else begin
            pool_enable <= data_valid && win;
            if (data_valid && win) meta_q <= {map, addr_c};
        end
    end

    delay_line #(
        .WIDTH (1),
        .DEPTH (POOL_LATENCY)
    ) u_valid_dl (
        .clk   (clk),
        .reset (reset),
        .d     (pool_enable),
        .q     (pool_out_valid)
    );

    delay_line #(
        .WIDTH (META_W),
        .DEPTH (POOL_LATENCY)
    ) u_meta_dl (
        .clk   (clk),
        .reset (reset),
        .d     (meta_q),
        .q     (meta_out)
    );

    assign pool_out_map  = meta_out[META_W-1:ADDR_W];
    assign pool_out_addr = meta_out[ADDR_W-1:0];

    assign frame_done = pool_out_valid
                     && (pool_out_addr == ADDR_LAST)
                     && (pool_out_map == MAP_LAST);

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer.
// Three instances: 4x4x1, 5x5x1 and 4x4x3 maps share one stream.
module tb_pool_window_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        data_valid = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] a_p1, a_p2, a_p3, a_p4;
    logic        a_en, a_ov, a_fd;
    logic [1:0]  a_addr;
    logic [0:0]  a_map;

    logic [31:0] b_p1, b_p2, b_p3, b_p4;
    logic        b_en, b_ov, b_fd;
    logic [1:0]  b_addr;
    logic [0:0]  b_map;

    logic [31:0] c_p1, c_p2, c_p3, c_p4;
    logic        c_en, c_ov, c_fd;
    logic [1:0]  c_addr;
    logic [1:0]  c_map;

    pool_window_buffer #(.IFM_SIZE(4), .IFM_DEPTH(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .pool_data_in_1(a_p1), .pool_data_in_2(a_p2),
        .pool_data_in_3(a_p3), .pool_data_in_4(a_p4),
        .pool_enable(a_en), .pool_out_valid(a_ov),
        .pool_out_addr(a_addr), .pool_out_map(a_map), .frame_done(a_fd)
    );

    pool_window_buffer #(.IFM_SIZE(5), .IFM_DEPTH(1)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .pool_data_in_1(b_p1), .pool_data_in_2(b_p2),
        .pool_data_in_3(b_p3), .pool_data_in_4(b_p4),
        .pool_enable(b_en), .pool_out_valid(b_ov),
        .pool_out_addr(b_addr), .pool_out_map(b_map), .frame_done(b_fd)
    );

    pool_window_buffer #(.IFM_SIZE(4), .IFM_DEPTH(3)) dut_c (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .pool_data_in_1(c_p1), .pool_data_in_2(c_p2),
        .pool_data_in_3(c_p3), .pool_data_in_4(c_p4),
        .pool_enable(c_en), .pool_out_valid(c_ov),
        .pool_out_addr(c_addr), .pool_out_map(c_map), .frame_done(c_fd)
    );

    int checks = 0;
    int failures = 0;

    int   cyc = 0;
    int   last_pix = 0;
    logic acc_q = 1'b0;
    int   gap_err = 0;

    logic [127:0] qa_taps[$];
    int           qa_epix[$];
    int           qa_ecyc[$];
    int           qa_addr[$];
    int           qa_fd[$];
    int           qa_ocyc[$];
    logic [127:0] qb_taps[$];
    int           qb_addr[$];
    int           qb_fd[$];
    int           qc_addr[$];
    int           qc_map[$];
    int           qc_fd[$];

    // Track accepted pixels and cycle count
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        acc_q <= data_valid && !reset;
        if (data_valid && !reset) last_pix <= int'(data_in);
    end

    // Record window and result events on the falling edge
    always @(negedge clk) begin
        if (a_en) begin
            qa_taps.push_back({a_p1, a_p2, a_p3, a_p4});
            qa_epix.push_back(last_pix);
            qa_ecyc.push_back(cyc);
            if (!acc_q) gap_err <= gap_err + 1;
        end
        if (a_ov) begin
            qa_addr.push_back(int'(a_addr));
            qa_fd.push_back(int'(a_fd));
            qa_ocyc.push_back(cyc);
        end
        if (b_en) qb_taps.push_back({b_p1, b_p2, b_p3, b_p4});
        if (b_ov) begin
            qb_addr.push_back(int'(b_addr));
            qb_fd.push_back(int'(b_fd));
        end
        if (c_ov) begin
            qc_addr.push_back(int'(c_addr));
            qc_map.push_back(int'(c_map));
            qc_fd.push_back(int'(c_fd));
        end
    end

    task automatic clear_q();
        qa_taps.delete(); qa_epix.delete(); qa_ecyc.delete();
        qa_addr.delete(); qa_fd.delete(); qa_ocyc.delete();
        qb_taps.delete(); qb_addr.delete(); qb_fd.delete();
        qc_addr.delete(); qc_map.delete(); qc_fd.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clear_q();
    endtask

    task automatic stream(input int base, input int n, input bit gap);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            data_in = 32'(base + i);
            data_valid = 1'b1;
            if (gap) begin
                @(negedge clk);
                data_valid = 1'b0;
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({a_en, a_ov, a_fd, a_addr, a_map} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0", {a_en, a_ov, a_fd, a_addr, a_map});
        end
        checks++;
        if ({a_p1, a_p2, a_p3, a_p4} !== 128'b0) begin
            failures++;
            $display("FAIL reset_taps: got %h expected 0", {a_p1, a_p2, a_p3, a_p4});
        end
        reset = 1'b0;
        clear_q();
    endtask

    task automatic test_basic();
        logic [127:0] et [4];
        int ep [4];
        et[0] = {32'd1, 32'd2, 32'd5, 32'd6};
        et[1] = {32'd3, 32'd4, 32'd7, 32'd8};
        et[2] = {32'd9, 32'd10, 32'd13, 32'd14};
        et[3] = {32'd11, 32'd12, 32'd15, 32'd16};
        ep = '{6, 8, 14, 16};
        apply_reset();
        stream(0, 16, 1'b0);
        drain();
        checks++;
        if (qa_taps.size() != 4) begin
            failures++;
            $display("FAIL basic_en_count: got %0d expected 4", qa_taps.size());
        end
        for (int i = 0; i < 4 && i < qa_taps.size(); i++) begin
            checks++;
            if (qa_taps[i] !== et[i]) begin
                failures++;
                $display("FAIL basic_taps[%0d]: got %h expected %h", i, qa_taps[i], et[i]);
            end
            checks++;
            if (qa_epix[i] != ep[i]) begin
                failures++;
                $display("FAIL basic_en_pixel[%0d]: got %0d expected %0d", i, qa_epix[i], ep[i]);
            end
        end
        checks++;
        if (qa_addr.size() != 4) begin
            failures++;
            $display("FAIL basic_out_count: got %0d expected 4", qa_addr.size());
        end
        for (int i = 0; i < 4 && i < qa_addr.size() && i < qa_ecyc.size(); i++) begin
            checks++;
            if (qa_addr[i] != i || qa_fd[i] != int'(i == 3)) begin
                failures++;
                $display("FAIL basic_out[%0d]: got addr %0d fd %0d expected addr %0d fd %0d",
                         i, qa_addr[i], qa_fd[i], i, int'(i == 3));
            end
            checks++;
            if (qa_ocyc[i] - qa_ecyc[i] != 3) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got %0d expected 3", i, qa_ocyc[i] - qa_ecyc[i]);
            end
        end
    endtask

    task automatic test_gaps();
        int g0;
        logic [127:0] et [4];
        et[0] = {32'd1, 32'd2, 32'd5, 32'd6};
        et[1] = {32'd3, 32'd4, 32'd7, 32'd8};
        et[2] = {32'd9, 32'd10, 32'd13, 32'd14};
        et[3] = {32'd11, 32'd12, 32'd15, 32'd16};
        apply_reset();
        g0 = gap_err;
        stream(0, 16, 1'b1);
        drain();
        checks++;
        if (qa_taps.size() != 4 || qa_addr.size() != 4) begin
            failures++;
            $display("FAIL gaps_count: got en %0d out %0d expected 4 4", qa_taps.size(), qa_addr.size());
        end
        for (int i = 0; i < 4 && i < qa_taps.size() && i < qa_addr.size(); i++) begin
            checks++;
            if (qa_taps[i] !== et[i] || qa_addr[i] != i) begin
                failures++;
                $display("FAIL gaps_win[%0d]: got %h addr %0d expected %h addr %0d",
                         i, qa_taps[i], qa_addr[i], et[i], i);
            end
        end
        checks++;
        if (gap_err != g0) begin
            failures++;
            $display("FAIL gaps_enable_in_gap: got %0d expected 0", gap_err - g0);
        end
    endtask

    task automatic test_size5();
        logic [127:0] et [5];
        et[0] = {32'd1, 32'd2, 32'd6, 32'd7};
        et[1] = {32'd3, 32'd4, 32'd8, 32'd9};
        et[2] = {32'd11, 32'd12, 32'd16, 32'd17};
        et[3] = {32'd13, 32'd14, 32'd18, 32'd19};
        et[4] = {32'd101, 32'd102, 32'd106, 32'd107};
        apply_reset();
        stream(0, 25, 1'b0);
        stream(100, 25, 1'b0);
        drain();
        checks++;
        if (qb_taps.size() != 8 || qb_addr.size() != 8) begin
            failures++;
            $display("FAIL size5_count: got en %0d out %0d expected 8 8", qb_taps.size(), qb_addr.size());
        end
        for (int i = 0; i < 5 && i < qb_taps.size(); i++) begin
            checks++;
            if (qb_taps[i] !== et[i]) begin
                failures++;
                $display("FAIL size5_taps[%0d]: got %h expected %h", i, qb_taps[i], et[i]);
            end
        end
        for (int i = 0; i < 8 && i < qb_addr.size(); i++) begin
            checks++;
            if (qb_addr[i] != i % 4 || qb_fd[i] != int'(i % 4 == 3)) begin
                failures++;
                $display("FAIL size5_out[%0d]: got addr %0d fd %0d expected addr %0d fd %0d",
                         i, qb_addr[i], qb_fd[i], i % 4, int'(i % 4 == 3));
            end
        end
    endtask

    task automatic test_depth3();
        apply_reset();
        stream(0, 48, 1'b0);
        drain();
        checks++;
        if (qc_addr.size() != 12) begin
            failures++;
            $display("FAIL depth3_count: got %0d expected 12", qc_addr.size());
        end
        for (int i = 0; i < 12 && i < qc_addr.size(); i++) begin
            checks++;
            if (qc_addr[i] != i % 4 || qc_map[i] != i / 4 || qc_fd[i] != int'(i == 11)) begin
                failures++;
                $display("FAIL depth3_out[%0d]: got a%0d m%0d fd%0d expected a%0d m%0d fd%0d",
                         i, qc_addr[i], qc_map[i], qc_fd[i], i % 4, i / 4, int'(i == 11));
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        stream(0, 10, 1'b0);
        reset = 1'b1;
        clear_q();
        @(negedge clk);
        #1;
        checks++;
        if ({a_en, a_ov, a_fd, a_addr, a_map, c_ov, c_map} !== 9'b0) begin
            failures++;
            $display("FAIL rmid_ctrl: got %b expected 0",
                     {a_en, a_ov, a_fd, a_addr, a_map, c_ov, c_map});
        end
        checks++;
        if ({a_p1, a_p2, a_p3, a_p4} !== 128'b0) begin
            failures++;
            $display("FAIL rmid_taps: got %h expected 0", {a_p1, a_p2, a_p3, a_p4});
        end
        @(negedge clk);
        reset = 1'b0;
        stream(200, 16, 1'b0);
        drain();
        checks++;
        if (qa_taps.size() < 1 || qa_taps[0] !== {32'd201, 32'd202, 32'd205, 32'd206}) begin
            failures++;
            $display("FAIL rmid_first_win: got %h expected %h",
                     (qa_taps.size() > 0) ? qa_taps[0] : 128'b0,
                     {32'd201, 32'd202, 32'd205, 32'd206});
        end
        checks++;
        if (qa_addr.size() != 4 || (qa_addr.size() > 0 && qa_addr[0] != 0)) begin
            failures++;
            $display("FAIL rmid_outs: got count %0d expected 4 starting at addr 0", qa_addr.size());
        end
    endtask

    task automatic test_drain();
        apply_reset();
        stream(0, 16, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (qa_addr.size() != 3) begin
            failures++;
            $display("FAIL drain_early: got %0d expected 3", qa_addr.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (qa_addr.size() != 4 || (qa_addr.size() == 4 && (qa_addr[3] != 3 || qa_fd[3] != 1))) begin
            failures++;
            $display("FAIL drain_last: got count %0d expected 4 with addr 3 and frame_done",
                     qa_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_size5();
        test_depth3();
        test_reset_mid();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
